// File: rtl/hawk_rr_txn_scheduler.sv
// ---------------------------------------------------------------------------
// hawk_rr_txn_scheduler : round-robin scheduler sharing one request/response
// server among N_REQ requesters.                              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hawk_rr_txn_scheduler #(
  parameter int N_REQ = 4,
  parameter int BREQ  = 64,
  parameter int BRSP  = 64,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0][BREQ-1:0] req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [BRSP-1:0]           rsp_data_o,
  output logic                      srv_valid_o,
  output logic [BREQ-1:0]           srv_data_o,
  input  logic                      srv_ready_i,
  input  logic                      srv_done_i,
  input  logic [BRSP-1:0]           srv_rsp_i,
  output logic                      busy_o,
  output logic [IDX_W-1:0]          gnt_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_gnt;
  logic [BREQ-1:0]    r_req;
  logic               r_srv_valid;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [BRSP-1:0]    r_rsp_data;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_cand;
  logic [N_REQ-1:0]   w_pick_oh;
  logic [N_REQ-1:0]   w_gnt_oh;
  int                 idx;

  // Scan from the requester after the last grant, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      w_cand = IDX_W'(idx);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_pick_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_gnt_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << r_gnt;
  assign req_ready_o = (r_state == S_IDLE && w_found) ? w_pick_oh : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_last      <= IDX_W'(N_REQ - 1);
      r_gnt       <= '0;
      r_req       <= '0;
      r_srv_valid <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_req       <= req_data_i[w_pick];
            r_gnt       <= w_pick;
            r_srv_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (srv_ready_i) begin
            r_srv_valid <= 1'b0;
            // A completion in the handshake cycle skips WAIT entirely.
            if (srv_done_i) begin
              r_rsp_valid <= w_gnt_oh;
              r_rsp_data  <= srv_rsp_i;
              r_state     <= S_RESP;
            end else begin
              r_state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (srv_done_i) begin
            r_rsp_valid <= w_gnt_oh;
            r_rsp_data  <= srv_rsp_i;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign srv_valid_o = r_srv_valid;
  assign srv_data_o  = r_req;
  assign busy_o      = (r_state != S_IDLE);
  assign gnt_idx_o   = r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_hawk_rr_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hawk_rr_txn_scheduler : directed + randomized bench against a
// transaction-level model of the round-robin scheduler.       Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hawk_rr_txn_scheduler;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0][63:0] req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [63:0]       rsp_data;
  logic              srv_valid;
  logic [63:0]       srv_data;
  logic              srv_ready;
  logic              srv_done;
  logic [63:0]       srv_rsp;
  logic              busy;
  logic [1:0]        gnt_idx;

  logic              rst3_n;
  logic [2:0]        v3;
  logic [2:0][63:0]  d3;
  logic [2:0]        ready3;
  logic [2:0]        rv3;
  logic [63:0]       rd3;
  logic              sv3;
  logic [63:0]       sd3;
  logic              rdy3;
  logic              dn3;
  logic              busy3;
  logic [1:0]        gnt3;

  always #5 clk = ~clk;

  hawk_rr_txn_scheduler #(.N_REQ(N), .BREQ(64), .BRSP(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .srv_valid_o(srv_valid), .srv_data_o(srv_data), .srv_ready_i(srv_ready),
    .srv_done_i(srv_done), .srv_rsp_i(srv_rsp), .busy_o(busy), .gnt_idx_o(gnt_idx)
  );

  hawk_rr_txn_scheduler #(.N_REQ(3), .BREQ(64), .BRSP(64)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .req_valid_i(v3), .req_data_i(d3),
    .req_ready_o(ready3), .rsp_valid_o(rv3), .rsp_data_o(rd3),
    .srv_valid_o(sv3), .srv_data_o(sd3), .srv_ready_i(rdy3),
    .srv_done_i(dn3), .srv_rsp_i(64'h0), .busy_o(busy3), .gnt_idx_o(gnt3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one transaction in flight, split into
  // "offered to server", "accepted by server" and "response cycle".
  bit          m_busy, m_issued, m_resp;
  int          m_gnt, m_last;
  logic [63:0] m_payload, m_rsp;
  logic [N-1:0] e_ready;
  int          e_pick;

  // Winner = valid requester with the smallest rotational distance after last.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      int d = (i - last - 1 + 2 * N) % N;
      if (v[i] && d < bestd) begin
        best = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_resp = 0;
    m_gnt = 0; m_last = N - 1;
    m_payload = '0; m_rsp = '0;
  endtask

  task automatic eval();
    bit offer;
    #1;
    e_ready = '0;
    e_pick  = -1;
    if (!m_busy) begin
      e_pick = rr_pick(req_valid, m_last);
      if (e_pick >= 0) e_ready[e_pick] = 1'b1;
    end
    offer = m_busy && !m_issued && !m_resp;
    check("req_ready", req_ready, e_ready);
    check("srv_valid", srv_valid, offer);
    if (offer) check("srv_data", srv_data, m_payload);
    check("rsp_valid", rsp_valid, m_resp ? (64'd1 << m_gnt) : 64'd0);
    check("rsp_data", rsp_data, m_resp ? m_rsp : 64'd0);
    check("busy", busy, m_busy);
    check("gnt_idx", gnt_idx, m_gnt);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_resp) begin
      m_resp = 0; m_busy = 0; m_last = m_gnt;
    end else if (!m_busy) begin
      if (e_pick >= 0) begin
        m_busy = 1; m_issued = 0; m_gnt = e_pick; m_payload = req_data[e_pick];
      end
    end else if (!m_issued) begin
      if (srv_ready) begin
        if (srv_done) begin m_resp = 1; m_rsp = srv_rsp; end
        else m_issued = 1;
      end
    end else if (srv_done) begin
      m_resp = 1; m_rsp = srv_rsp;
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] v, input logic rdy,
                     input logic dn, input logic [63:0] rsp);
    @(negedge clk);
    rst_n = r; req_valid = v; srv_ready = rdy; srv_done = dn; srv_rsp = rsp;
    eval();
  endtask

  task automatic t3(input logic [2:0] v, input logic [2:0] exp);
    @(negedge clk);
    v3 = v;
    #1 check("n3_ready", ready3, exp);
    @(negedge clk);
    v3 = '0; rdy3 = 1'b1; dn3 = 1'b1;
    #1 check("n3_srv_valid", sv3, 1);
    @(negedge clk);
    rdy3 = 1'b0; dn3 = 1'b0;
    #1 check("n3_rsp_valid", rv3, exp);
  endtask

  bit          pend [N];
  logic [63:0] pdata [N];
  int          waits [N];

  initial begin
    rst_n = 0; req_valid = '0; req_data = '0; srv_ready = 0; srv_done = 0; srv_rsp = '0;
    rst3_n = 0; v3 = '0; d3 = '0; rdy3 = 0; dn3 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1; rst3_n = 1;

    // Non-power-of-two wrap.
    t3(3'b011, 3'b001);
    t3(3'b110, 3'b010);
    t3(3'b101, 3'b100);
    t3(3'b001, 3'b001);

    // Reset state, then single transaction with a slow server.
    cyc(1, 4'b0000, 0, 0, 0);
    req_data[2] = 64'hA5;
    cyc(1, 4'b0100, 0, 0, 0);
    cyc(1, 4'b0000, 0, 1, 64'hDEAD);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 1, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 1, 64'h5A);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 1, 64'hBAD);

    // Backpressure then ready+done together.
    req_data[3] = 64'h1234_5678_9ABC_DEF0;
    cyc(1, 4'b1000, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 1, 1, 64'h77);
    cyc(1, 4'b0000, 0, 0, 0);

    // Reset during WAIT drops the transaction; priority restarts at 0.
    req_data[1] = 64'h11;
    cyc(1, 4'b0010, 0, 0, 0);
    cyc(1, 4'b0000, 1, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 1, 64'h99);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 1, 1, 64'h42);
    cyc(1, 4'b0000, 0, 0, 0);

    // Randomized traffic with protocol-abiding requesters.
    for (int i = 0; i < N; i++) begin pend[i] = 0; pdata[i] = '0; waits[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; pdata[i] = {$urandom, $urandom};
        end
        req_valid[i] = pend[i] && rst_n;
        req_data[i]  = pend[i] ? pdata[i] : {$urandom, $urandom};
      end
      srv_ready = $urandom_range(0, 1);
      srv_done  = ($urandom_range(0, 2) == 0);
      srv_rsp   = {$urandom, $urandom};
      eval();
      if (!rst_n) begin
        for (int i = 0; i < N; i++) waits[i] = 0;
      end else if (e_pick >= 0) begin
        check("fairness", waits[e_pick] <= N - 1, 1);
        waits[e_pick] = 0;
        pend[e_pick] = 0;
        for (int i = 0; i < N; i++) if (pend[i]) waits[i]++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
